// File: rtl/gate_table_sweeper_if.sv
// Bundle of the sweeper's control and result signals.
// The master side requests sweeps; the slave side streams rows and results.
interface gate_table_sweeper_if #(
    parameter int N = 2
);
    localparam int ROWS = 1 << N;

    logic            start;
    logic [2:0]      mode;
    logic            busy;
    logic            valid;
    logic [N-1:0]    a_out;
    logic            s_out;
    logic            done;
    logic [ROWS-1:0] table_out;
    logic [N:0]      ones_count;

    modport master (
        output start, mode,
        input  busy, valid, a_out, s_out, done, table_out, ones_count
    );

    modport slave (
        input  start, mode,
        output busy, valid, a_out, s_out, done, table_out, ones_count
    );
endinterface

// File: rtl/gate_table_sweeper.sv
// Truth-table engine: walks every N-input combination, one per clock,
// streaming (inputs, result) rows and building a bitmap and a ones count.
module gate_table_sweeper #(
    parameter int N = 2
) (
    input logic                 clk,
    input logic                 reset,
    gate_table_sweeper_if.slave bus
);
    localparam int ROWS = 1 << N;
    localparam logic [N-1:0] LAST = N'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    cnt;
    logic [2:0]      mode_q;
    logic            busy;
    logic            valid;
    logic            done;
    logic [ROWS-1:0] tbl;
    logic [N:0]      ones;
    logic            f;

    // Selected function of the current combination; codes 6 and 7 read as 0.
    always_comb begin
        f = 1'b0;
        unique case (mode_q)
            3'd0:    f = ~|cnt;
            3'd1:    f = ~&cnt;
            3'd2:    f = &cnt;
            3'd3:    f = |cnt;
            3'd4:    f = ^cnt;
            3'd5:    f = ~^cnt;
            default: f = 1'b0;
        endcase
    end

    // Sweep control: accept start in IDLE, record one row per clock, then pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            done   <= 1'b0;
            tbl    <= '0;
            ones   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        cnt    <= '0;
                        tbl    <= '0;
                        ones   <= '0;
                        busy   <= 1'b1;
                        valid  <= 1'b1;
                        state  <= SWEEP;
                    end
                end
                SWEEP: begin
                    tbl[cnt] <= f;
                    ones     <= ones + {{N{1'b0}}, f};
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row outputs read as zero whenever no row is being presented.
    assign bus.a_out      = valid ? cnt : '0;
    assign bus.s_out      = valid & f;
    assign bus.busy       = busy;
    assign bus.valid      = valid;
    assign bus.done       = done;
    assign bus.table_out  = tbl;
    assign bus.ones_count = ones;
endmodule

// File: tb/tb_gate_table_sweeper.sv
// Bench for gate_table_sweeper: three instances (N=2,3,6), a row scoreboard
// per instance, a table of whole-sweep vectors and a few corner sequences.
module tb_gate_table_sweeper;
    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst3 = 1'b1;
    logic rst6 = 1'b1;

    always #5 clk = ~clk;

    gate_table_sweeper_if #(.N(2)) b2();
    gate_table_sweeper_if #(.N(3)) b3();
    gate_table_sweeper_if #(.N(6)) b6();

    gate_table_sweeper #(.N(2)) d2 (.clk(clk), .reset(rst2), .bus(b2.slave));
    gate_table_sweeper #(.N(3)) d3 (.clk(clk), .reset(rst3), .bus(b3.slave));
    gate_table_sweeper #(.N(6)) d6 (.clk(clk), .reset(rst6), .bus(b6.slave));

    int total = 0;
    int passed = 0;

    int q2[$];
    int q3[$];
    int q6[$];

    typedef struct {
        logic        busy;
        logic        valid;
        logic        done;
        logic        s;
        logic [63:0] a;
        logic [63:0] tbl;
        int          ones;
    } obs_t;

    typedef struct {
        int          n;
        logic [2:0]  mode;
        logic [63:0] exp_tbl;
        int          exp_ones;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic fm(input int n, input logic [2:0] md, input int m);
        int all;
        all = (1 << n) - 1;
        case (md)
            3'd0: return m == 0;
            3'd1: return m != all;
            3'd2: return m == all;
            3'd3: return m != 0;
            3'd4: return ($countones(m) % 2) == 1;
            3'd5: return ($countones(m) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t obs(input int n);
        obs_t o;
        o = '{default: '0};
        case (n)
            2: begin
                o.busy = b2.busy; o.valid = b2.valid; o.done = b2.done;
                o.s = b2.s_out; o.a = 64'(b2.a_out);
                o.tbl = 64'(b2.table_out); o.ones = int'(b2.ones_count);
            end
            3: begin
                o.busy = b3.busy; o.valid = b3.valid; o.done = b3.done;
                o.s = b3.s_out; o.a = 64'(b3.a_out);
                o.tbl = 64'(b3.table_out); o.ones = int'(b3.ones_count);
            end
            default: begin
                o.busy = b6.busy; o.valid = b6.valid; o.done = b6.done;
                o.s = b6.s_out; o.a = 64'(b6.a_out);
                o.tbl = 64'(b6.table_out); o.ones = int'(b6.ones_count);
            end
        endcase
        return o;
    endfunction

    task automatic drive(input int n, input logic st, input logic [2:0] md);
        case (n)
            2: begin b2.start = st; b2.mode = md; end
            3: begin b3.start = st; b3.mode = md; end
            default: begin b6.start = st; b6.mode = md; end
        endcase
    endtask

    task automatic push_rows(input int n, input logic [2:0] md);
        for (int m = 0; m < (1 << n); m++) begin
            int e;
            e = m * 2 + int'(fm(n, md, m));
            case (n)
                2: q2.push_back(e);
                3: q3.push_back(e);
                default: q6.push_back(e);
            endcase
        end
    endtask

    function automatic int qsize(input int n);
        case (n)
            2: return q2.size();
            3: return q3.size();
            default: return q6.size();
        endcase
    endfunction

    // Row scoreboards: every valid row is popped and compared.
    always @(negedge clk) begin
        if (b2.valid) begin
            int e;
            e = (q2.size() > 0) ? q2.pop_front() : -1;
            check("row2", {b2.a_out, b2.s_out}, 64'(e));
        end
        if (b3.valid) begin
            int e;
            e = (q3.size() > 0) ? q3.pop_front() : -1;
            check("row3", {b3.a_out, b3.s_out}, 64'(e));
        end
        if (b6.valid) begin
            int e;
            e = (q6.size() > 0) ? q6.pop_front() : -1;
            check("row6", {b6.a_out, b6.s_out}, 64'(e));
        end
    end

    task automatic run(input int n, input logic [2:0] md,
                       input logic [63:0] et, input int eo, input string nm);
        int rows;
        int c;
        bit seen;
        obs_t o;
        rows = 1 << n;
        @(negedge clk);
        push_rows(n, md);
        drive(n, 1'b1, md);
        @(posedge clk);
        #1;
        drive(n, 1'b0, md);
        o = obs(n);
        check({nm, " clr"}, o.tbl, 64'd0);
        c = 0;
        seen = 1'b0;
        while (!seen && c < rows + 8) begin
            @(negedge clk);
            c++;
            o = obs(n);
            if (o.done) seen = 1'b1;
        end
        check({nm, " done_lat"}, 64'(c), 64'(rows + 1));
        check({nm, " tbl"}, o.tbl, et);
        check({nm, " ones"}, 64'(o.ones), 64'(eo));
        check({nm, " rows_left"}, 64'(qsize(n)), 64'd0);
        @(negedge clk);
        o = obs(n);
        check({nm, " done_pulse"}, {o.busy, o.valid, o.done}, 64'd0);
        check({nm, " hold"}, o.tbl, et);
    endtask

    vec_t vecs[7];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t o;
        int c;
        int cb;
        bit seen;

        vecs[0] = '{2, 3'd0, 64'h1, 1, "nor2"};
        vecs[1] = '{3, 3'd1, 64'h7F, 7, "nand3"};
        vecs[2] = '{3, 3'd2, 64'h80, 1, "and3"};
        vecs[3] = '{3, 3'd4, 64'h96, 4, "xor3"};
        vecs[4] = '{3, 3'd5, 64'h69, 4, "xnor3"};
        vecs[5] = '{6, 3'd7, 64'h0, 0, "rsv6"};
        vecs[6] = '{6, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 63, "or6"};

        drive(2, 1'b0, 3'd0);
        drive(3, 1'b0, 3'd0);
        drive(6, 1'b0, 3'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            int n;
            n = (i == 0) ? 2 : (i == 1) ? 3 : 6;
            o = obs(n);
            check($sformatf("rst%0d ctl", n), {o.busy, o.valid, o.done, o.s}, 64'd0);
            check($sformatf("rst%0d a", n), o.a, 64'd0);
            check($sformatf("rst%0d tbl", n), o.tbl + 64'(o.ones), 64'd0);
        end

        rst2 = 1'b0;
        rst3 = 1'b0;
        rst6 = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run(vecs[i].n, vecs[i].mode, vecs[i].exp_tbl, vecs[i].exp_ones, vecs[i].name);

        // OR sweep with start re-pulsed and mode changed mid-sweep.
        @(negedge clk);
        push_rows(2, 3'd3);
        drive(2, 1'b1, 3'd3);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 3'd3);
        c = 0;
        cb = 0;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            if (b2.busy) cb++;
            if (b2.done) seen = 1'b1;
            if (c == 1) drive(2, 1'b1, 3'd0);
            if (c == 3) drive(2, 1'b0, 3'd0);
        end
        check("or2 busy_cycles", 64'(cb), 64'd4);
        check("or2 done_lat", 64'(c), 64'd5);
        check("or2 tbl", 64'(b2.table_out), 64'hE);
        check("or2 ones", 64'(b2.ones_count), 64'd3);
        repeat (2) @(negedge clk);
        check("or2 no_restart", {b2.busy, b2.valid}, 64'd0);

        // Asynchronous reset while row 3 is presented.
        @(negedge clk);
        push_rows(3, 3'd0);
        drive(3, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 3'd0);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            if (b3.valid && b3.a_out == 3'd3) seen = 1'b1;
        end
        check("rst_mid reach_row3", 64'(seen), 64'd1);
        #2;
        rst3 = 1'b1;
        #1;
        o = obs(3);
        check("rst_mid ctl", {o.busy, o.valid, o.done, o.s}, 64'd0);
        check("rst_mid a", o.a, 64'd0);
        check("rst_mid tbl", o.tbl, 64'd0);
        check("rst_mid ones", 64'(o.ones), 64'd0);
        q3.delete();
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        run(3, 3'd0, 64'h01, 1, "nor3_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gate_table_sweeper.md
Name: gate_table_sweeper

Overview:
Parametrised successor to the fixed two-input NOR gate blocks. It evaluates a selectable N-input logic function over every input combination m = 0 .. 2^N-1, one combination per clock. It streams each row (inputs, result) and accumulates a full truth-table bitmap plus a count of true rows. It is the self-checking truth-table engine for the gate exercises, replacing the hand-written stimulus sequences in testbenches.

Parameters:
N, 2, number of gate inputs; legal range 1..6
ROWS, 2**N, derived; number of truth-table rows (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
mode  input  3  function select, latched on accepted start
busy  output  1  high while sweeping
valid  output  1  high when a_out/s_out hold a current row
a_out  output  N  current combination m; bit N-1 = first (MSB) input
s_out  output  1  function result for a_out
done  output  1  one-cycle pulse after the last row
table_out  output  ROWS  bit m = f(m); holds after done
ones_count  output  N+1  number of rows with f(m)=1

Behaviour:
- Reset is asynchronous and active-high, with one clock. While reset is high: state=IDLE; busy=0, valid=0, done=0, a_out=0, s_out=0, table_out=0, ones_count=0, internal mode_q=0.
- Functions over the bits of m, selected by mode_q:
  - 0 NOR: 1 iff all bits are 0. This is the N-input generalisation of ~a&~b.
  - 1 NAND, 2 AND, 3 OR.
  - 4 XOR: odd parity. 5 XNOR: even parity.
  - 6, 7: reserved; f=0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - busy=0, valid=0, done=0.
  - On a clock edge with start=1: mode_q<=mode, cnt<=0, table_out<=0, ones_count<=0, go to SWEEP.
- SWEEP:
  - busy=1, valid=1, a_out=cnt.
  - s_out=f(cnt, mode_q), combinational from registers.
  - Each edge: table_out[cnt]<=s_out; ones_count<=ones_count+s_out; cnt<=cnt+1.
  - When cnt==ROWS-1, go to DONE instead; cnt does not wrap into a second pass.
- DONE:
  - done=1 for exactly one cycle; busy=0, valid=0. Then go to IDLE.
- Latency: start accepted at edge k. Rows appear in cycles k+1 .. k+ROWS. The done cycle is k+ROWS+1. The next start is accepted no earlier than the edge ending the done cycle's successor IDLE cycle.
- start is ignored in SWEEP and DONE.
- mode changes after acceptance have no effect on the running sweep.
- table_out and ones_count are stable from the done cycle until the next accepted start. Both are cleared on that start edge.
- Reset asserted mid-sweep aborts immediately to reset values. There is no partial-result retention.
- ones_count width N+1 holds ROWS (all-ones function) without overflow.
- a_out and s_out are 0 when valid=0.

Test Plan:
- N=2, mode=0 (NOR), start one cycle -> rows (00,1),(01,0),(10,0),(11,0); table_out=4'b0001; ones_count=1; done pulses exactly 5 cycles after the start edge.
- N=3, mode=1 (NAND) -> table_out=8'h7F, ones_count=7. N=3, mode=2 (AND) -> table_out=8'h80, ones_count=1.
- N=3, mode=4 (XOR) -> table_out=8'h96, ones_count=4. Then mode=5 (XNOR) -> table_out=8'h69, ones_count=4; the second start clears the previous results.
- N=2, mode=3: pulse start and toggle mode to 0 during SWEEP -> start ignored; busy stays high for exactly 4 cycles; result still OR: table_out=4'b1110, ones_count=3.
- N=3, mode=0: assert reset asynchronously (between edges) at row 3 -> all outputs 0 immediately. A fresh start after release gives table_out=8'h01.
- N=6, mode=7 (reserved) -> 64 valid rows with s_out=0; table_out=0, ones_count=0. N=6, mode=3 -> ones_count=63, table_out bit 0 = 0.
